// File: rtl/gpu_sync_fifo_std.sv
// Single-clock standard-mode FIFO: registered read data one cycle after an accepted read,
// registered status flags computed from the next level, and one-cycle overflow/underflow pulses.
module gpu_sync_fifo_std #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter int unsigned AFULL_LEVEL = (1 << ADDR_WIDTH) - 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   output logic                  full_o,
   output logic                  almost_full_o,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] dout_o,
   output logic                  empty_o,
   output logic [ADDR_WIDTH:0]   level_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam int unsigned          DEPTH      = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]  FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]  AF_LEVEL   = AFULL_LEVEL[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wp;
   logic [ADDR_WIDTH-1:0] rp;
   logic [ADDR_WIDTH:0]   level;
   logic [ADDR_WIDTH:0]   level_nxt;
   logic                  wr_acc;
   logic                  rd_acc;

   assign wr_acc  = wr_en_i && !full_o;
   assign rd_acc  = rd_en_i && !empty_o;
   assign level_o = level;

   always_comb begin
      level_nxt = level;
      if (wr_acc && !rd_acc) begin
         level_nxt = level + (ADDR_WIDTH + 1)'(1);
      end else if (rd_acc && !wr_acc) begin
         level_nxt = level - (ADDR_WIDTH + 1)'(1);
      end
   end

   // Storage is not reset; writes are suppressed in the reset cycle so requests there are ignored.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem[wp] <= din_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp            <= '0;
         rp            <= '0;
         level         <= '0;
         dout_o        <= '0;
         empty_o       <= 1'b1;
         full_o        <= 1'b0;
         almost_full_o <= (AF_LEVEL == '0);
         overflow_o    <= 1'b0;
         underflow_o   <= 1'b0;
      end else begin
         if (wr_acc) begin
            wp <= wp + ADDR_WIDTH'(1);
         end
         if (rd_acc) begin
            dout_o <= mem[rp];
            rp     <= rp + ADDR_WIDTH'(1);
         end
         level         <= level_nxt;
         // Flags track the next level so they agree with level_o in the same cycle.
         empty_o       <= (level_nxt == '0);
         full_o        <= (level_nxt == FULL_LEVEL);
         almost_full_o <= (level_nxt >= AF_LEVEL);
         overflow_o    <= wr_en_i && full_o;
         underflow_o   <= rd_en_i && empty_o;
      end
   end

endmodule

// File: tb/tb_gpu_sync_fifo_std.sv
// Scoreboard bench for gpu_sync_fifo_std (DEPTH=4, AFULL_LEVEL=3): the driver predicts read
// data into a queue, and a monitor pops and compares whenever the FIFO presents a read word.
module tb_gpu_sync_fifo_std;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 2;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en_i = 1'b0;
   logic [DW-1:0] din_i = '0;
   logic          full_o;
   logic          almost_full_o;
   logic          rd_en_i = 1'b0;
   logic [DW-1:0] dout_o;
   logic          empty_o;
   logic [AW:0]   level_o;
   logic          overflow_o;
   logic          underflow_o;

   gpu_sync_fifo_std #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LEVEL(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_en_i       (wr_en_i),
      .din_i         (din_i),
      .full_o        (full_o),
      .almost_full_o (almost_full_o),
      .rd_en_i       (rd_en_i),
      .dout_o        (dout_o),
      .empty_o       (empty_o),
      .level_o       (level_o),
      .overflow_o    (overflow_o),
      .underflow_o   (underflow_o)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned fails  = 0;

   logic [DW-1:0] exp_q [$];   // expected read words, in order
   logic [DW-1:0] mdata [$];   // model of stored contents
   int unsigned   mlevel = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; status outputs are checked 1ns after the edge.
   task automatic step(input logic r, input logic wr, input logic [DW-1:0] d, input logic rd);
      logic wa, ra, e_ovf, e_udf;
      @(negedge clk);
      rst = r; wr_en_i = wr; din_i = d; rd_en_i = rd;
      if (r) begin
         mdata.delete();
         mlevel = 0;
         e_ovf = 1'b0;
         e_udf = 1'b0;
      end else begin
         wa = wr && (mlevel != DEPTH);
         ra = rd && (mlevel != 0);
         e_ovf = wr && !wa;
         e_udf = rd && !ra;
         if (ra) begin
            exp_q.push_back(mdata.pop_front());
            mlevel--;
         end
         if (wa) begin
            mdata.push_back(d);
            mlevel++;
         end
      end
      @(posedge clk);
      #1;
      check("level", int'(level_o), int'(mlevel));
      check("empty", int'(empty_o), int'(mlevel == 0));
      check("full", int'(full_o), int'(mlevel == DEPTH));
      check("almost_full", int'(almost_full_o), int'(mlevel >= 3));
      check("overflow", int'(overflow_o), int'(e_ovf));
      check("underflow", int'(underflow_o), int'(e_udf));
   endtask

   // Monitor: a read word is presented after any edge where a read was accepted.
   logic [DW-1:0] held = '0;
   always @(posedge clk) begin
      logic vld, r;
      logic [DW-1:0] e;
      vld = rd_en_i && !empty_o && !rst;
      r   = rst;
      #1;
      if (r) begin
         held = '0;
         check("dout_reset", int'(dout_o), 0);
      end else if (vld) begin
         if (exp_q.size() == 0) begin
            check("unexpected_read_word", int'(dout_o), -1);
         end else begin
            e = exp_q.pop_front();
            held = e;
            check("dout", int'(dout_o), int'(e));
         end
      end else begin
         check("dout_hold", int'(dout_o), int'(held));
      end
   end

   initial begin
      // reset
      step(1, 0, 8'h00, 0);
      step(1, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);

      // fill, overflow, drain
      step(0, 1, 8'h11, 0);
      step(0, 1, 8'h22, 0);
      step(0, 1, 8'h33, 0);
      step(0, 1, 8'h44, 0);
      step(0, 1, 8'h55, 0);
      step(0, 0, 8'h00, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);

      // underflow: dout must keep 0x44
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);

      // wrap with concurrent read/write at level 2
      step(0, 1, 8'h50, 0);
      step(0, 1, 8'h51, 0);
      for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h60 + i), 1);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);

      // full with read+write: read wins, write overflows
      for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h70 + i), 0);
      step(0, 1, 8'h77, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);

      // empty with read+write: write wins, read underflows
      step(0, 1, 8'h88, 1);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);

      // flow-controlled random stream, as the FWFT adapter would drive it
      for (int i = 0; i < 2000; i++) begin
         logic w, rr;
         w  = ($urandom_range(1, 0) == 1) && (mlevel != DEPTH);
         rr = ($urandom_range(1, 0) == 1) && (mlevel != 0);
         step(0, w, 8'($urandom), rr);
      end
      while (mlevel != 0) step(0, 0, 8'h00, 1);

      // reset at level 3 with requests present
      step(0, 1, 8'hD1, 0);
      step(0, 1, 8'hD2, 0);
      step(0, 1, 8'hD3, 0);
      step(1, 1, 8'hEE, 1);
      step(0, 0, 8'h00, 1);
      step(0, 1, 8'hA1, 0);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/gpu_sync_fifo_std.md
# gpu_sync_fifo_std

Single-clock, standard-mode (non-FWFT) FIFO with registered read data: a word is presented on `dout_o` one cycle after `rd_en_i` is accepted. It sits directly upstream of the GPU's FWFT adapter. It drives that adapter's `fifo_empty_i` and `fifo_dout_i` inputs, and it takes the adapter's `fifo_rd_en_o` output as its own `rd_en_i`. It also gives the producer side full, almost-full and level status, plus overflow/underflow error pulses.

## Interface
- `DATA_WIDTH`, default 32: word width in bits.
- `ADDR_WIDTH`, default 4: depth is DEPTH = 2^ADDR_WIDTH words.
- `AFULL_LEVEL`, default DEPTH-2: `almost_full_o` asserts when level >= AFULL_LEVEL. Legal range is 1..DEPTH.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous reset, active-high. Clock is `clk`.
- `wr_en_i` in 1: write request.
- `din_i` in DATA_WIDTH: write data.
- `full_o` out 1: level == DEPTH.
- `almost_full_o` out 1: level >= AFULL_LEVEL.
- `rd_en_i` in 1: read request.
- `dout_o` out DATA_WIDTH: read data, valid on the cycle after an accepted read.
- `empty_o` out 1: level == 0.
- `level_o` out ADDR_WIDTH+1: number of stored words, 0..DEPTH.
- `overflow_o` out 1: one-cycle pulse when a write is rejected.
- `underflow_o` out 1: one-cycle pulse when a read is rejected.

## Operation
- Storage: DEPTH x DATA_WIDTH array, one write port and one read port, both synchronous.
  - Write pointer `wp` and read pointer `rp` are ADDR_WIDTH bits and wrap modulo DEPTH.
  - Level is held as a registered counter.
- Accept rules, all sampled at the rising edge:
  - wr_acc = `wr_en_i` && !`full_o`.
  - rd_acc = `rd_en_i` && !`empty_o`.
- Write when full: rejected, even if a read is accepted in the same cycle. No data is stored, `wp` holds, and `overflow_o` = 1 on the next cycle.
- Read when empty: rejected, even if a write is accepted in the same cycle. `rp` holds, `dout_o` holds its previous value, and `underflow_o` = 1 on the next cycle.
- On wr_acc: mem[wp] <= `din_i`; wp <= wp+1.
- On rd_acc: `dout_o` <= mem[rp]; rp <= rp+1.
- Level update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both are accepted or neither is.
- Flags are registered and derived from the next level value, so they are exact in the same cycle `level_o` updates:
  - `empty_o` = (next level == 0).
  - `full_o` = (next level == DEPTH).
  - `almost_full_o` = (next level >= AFULL_LEVEL).
- Read/write address collision:
  - A read needs level >= 1 and a write needs level < DEPTH, so rp == wp with both accepted is impossible.
  - No bypass path is required.
- `dout_o` changes only on rd_acc or reset. The FWFT adapter relies on this hold behaviour.
- Reset values:
  - wp = rp = 0, level 0.
  - `empty_o` = 1, `full_o` = 0.
  - `almost_full_o` = 1 only if AFULL_LEVEL == 0, which is illegal, so effectively 0.
  - `dout_o` = 0, `overflow_o` = `underflow_o` = 0.
  - Memory contents are not reset.
- Reset mid-operation discards all stored words. Requests in the reset cycle are ignored and do not raise error pulses.

## Timing
- Write to read availability: a write accepted at edge N makes `empty_o` fall after edge N. A read can then be accepted at edge N+1, and the data appears on `dout_o` after edge N+1.
  - The minimum write-to-data latency is 2 cycles.
- Read latency is exactly 1 cycle from the accepting edge to `dout_o`.
- Back-to-back reads return one word per cycle in write order.
- Simultaneous read and write at level 1..DEPTH-1 sustain full throughput with the level constant.
- Full deasserts the cycle after a read is accepted, so a write can be accepted at the next edge.
- Error pulses last exactly one cycle per rejected request. They stay high for consecutive rejected cycles.
- No combinational path from any input to any output.

## Test plan
Bench configuration: DATA_WIDTH=8, ADDR_WIDTH=2 (DEPTH=4), AFULL_LEVEL=3.

- Reset check: hold `rst` for 2 cycles, then release.
  - Required: `empty_o`=1, `full_o`=0, `almost_full_o`=0, `level_o`=0, `dout_o`=0x00, no error pulses.
- Fill and drain: write 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Required level sequence 1,2,3,4; `almost_full_o` rises at level 3; `full_o` rises at level 4.
  - A 5th write of 0x55 gives a single `overflow_o` pulse and level stays 4.
  - Four reads return 0x11, 0x22, 0x33, 0x44, each one cycle after its read is accepted.
- Underflow: read while empty.
  - Required: `underflow_o` pulses for 1 cycle, `dout_o` holds 0x44, level stays 0.
- Wrap and concurrency: at level 2, assert read and write together for 10 cycles with data 0x60..0x69.
  - Required: level stays 2, pointers wrap at least twice, output order is strictly FIFO.
- Boundary cases:
  - Full with read and write in the same cycle: the read is accepted, the write is rejected with `overflow_o`, and level goes 4 to 3.
  - Empty with read and write in the same cycle: the write is accepted, the read is rejected with `underflow_o`, and level goes 0 to 1.
- Adapter integration: drive the FWFT adapter from this block with random write bursts and a random consumer `rd_en` (50% duty, 1000 words).
  - Required: the consumer sees every word in order, with no loss or duplication, and no error pulses.
- Mid-operation reset: assert `rst` at level 3.
  - Required: level 0 and `empty_o`=1 the next cycle, and old data is never output afterwards.
